// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with write bypass, busy scoreboard, debug port and writeback counter
module reg_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              rs1_en,
  input  logic              rs2_en,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              reg_write,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              stall,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wb_count
);
  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [15:0]       wb_count_q, wb_count_d;
  logic              we, ie, hit1, hit2;

  // r0 writes/issues are dropped entirely when r0 is hardwired to zero
  assign we   = reg_write & ~(ZERO_R0 & (rd == '0));
  assign ie   = issue_valid & ~(ZERO_R0 & (issue_rd == '0));
  assign hit1 = BYPASS & we & (rd == rs1);
  assign hit2 = BYPASS & we & (rd == rs2);

  assign rs1_data   = hit1 ? rd_data : regs_q[rs1];
  assign rs2_data   = hit2 ? rd_data : regs_q[rs2];
  assign rs1_busy   = busy_q[rs1] & ~hit1;
  assign rs2_busy   = busy_q[rs2] & ~hit2;
  assign stall      = (rs1_en & rs1_busy) | (rs2_en & rs2_busy);
  assign dbg_data   = regs_q[dbg_addr];
  assign wb_count   = wb_count_q;
  assign wb_count_d = we ? wb_count_q + 16'd1 : wb_count_q;

  // next busy vector: a new producer (issue) beats a completing writeback
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++)
      busy_d[i] = (ie && issue_rd == ADDR_W'(i)) ? 1'b1 :
                  (we && rd == ADDR_W'(i)) ? 1'b0 : busy_q[i];
  end

  // register array, scoreboard and counter state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      wb_count_q <= '0;
    end else begin
      if (we) regs_q[rd] <= rd_data;
      busy_q     <= busy_d;
      wb_count_q <= wb_count_d;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: checks two configurations (bypass/no-zero and no-bypass/zero-r0) against an array model
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  rs1, rs2, rd, issue_rd, dbg_addr;
  logic        rs1_en, rs2_en, reg_write, issue_valid;
  logic [15:0] rd_data;
  logic [15:0] a_rs1_data, a_rs2_data, a_dbg_data, a_wb_count;
  logic [15:0] b_rs1_data, b_rs2_data, b_dbg_data, b_wb_count;
  logic        a_rs1_busy, a_rs2_busy, a_stall, b_rs1_busy, b_rs2_busy, b_stall;

  int checks = 0;
  int errors = 0;
  int mreg [2][8];
  bit mbusy [2][8];
  int mcnt [2];
  bit zr [2] = '{1'b0, 1'b1};
  bit bp [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .rs1_data(a_rs1_data), .rs2_data(a_rs2_data), .rd(rd), .rd_data(rd_data),
    .reg_write(reg_write), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy), .stall(a_stall),
    .dbg_addr(dbg_addr), .dbg_data(a_dbg_data), .wb_count(a_wb_count));

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data), .rd(rd), .rd_data(rd_data),
    .reg_write(reg_write), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy), .stall(b_stall),
    .dbg_addr(dbg_addr), .dbg_data(b_dbg_data), .wb_count(b_wb_count));

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic bit m_we(input int k);
    return reg_write && !(zr[k] && rd == 0);
  endfunction

  function automatic int m_rd(input int k, input int a);
    if (bp[k] && m_we(k) && rd == a) return int'(rd_data);
    return (zr[k] && a == 0) ? 0 : mreg[k][a];
  endfunction

  function automatic bit m_busy(input int k, input int a);
    return mbusy[k][a] && !(bp[k] && m_we(k) && rd == a);
  endfunction

  function automatic void m_clear(input int k);
    for (int i = 0; i < 8; i++) begin
      mreg[k][i] = 0;
      mbusy[k][i] = 1'b0;
    end
    mcnt[k] = 0;
  endfunction

  function automatic void m_update(input int k);
    bit ie;
    ie = issue_valid && !(zr[k] && issue_rd == 0);
    if (!reset) begin
      m_clear(k);
      return;
    end
    if (m_we(k)) begin
      mreg[k][rd] = int'(rd_data);
      mbusy[k][rd] = 1'b0;
      mcnt[k] = (mcnt[k] + 1) % 65536;
    end
    if (ie) mbusy[k][issue_rd] = 1'b1;
  endfunction

  task automatic check_all(input int k);
    bit b1, b2;
    b1 = m_busy(k, rs1);
    b2 = m_busy(k, rs2);
    chk("rs1_data", k, k ? b_rs1_data : a_rs1_data, m_rd(k, rs1));
    chk("rs2_data", k, k ? b_rs2_data : a_rs2_data, m_rd(k, rs2));
    chk("rs1_busy", k, k ? b_rs1_busy : a_rs1_busy, b1);
    chk("rs2_busy", k, k ? b_rs2_busy : a_rs2_busy, b2);
    chk("stall", k, k ? b_stall : a_stall, (rs1_en && b1) || (rs2_en && b2));
    chk("dbg_data", k, k ? b_dbg_data : a_dbg_data, mreg[k][dbg_addr]);
    chk("wb_count", k, k ? b_wb_count : a_wb_count, mcnt[k]);
  endtask

  task automatic dbg_sweep(input string tag);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      chk(tag, 0, a_dbg_data, mreg[0][a]);
      chk(tag, 1, b_dbg_data, mreg[1][a]);
    end
  endtask

  task automatic idle();
    reg_write = 0; issue_valid = 0; rs1_en = 0; rs2_en = 0;
    rd = 0; rd_data = 0; issue_rd = 0; rs1 = 0; rs2 = 0; dbg_addr = 0;
  endtask

  task automatic step(input bit do_chk);
    #2;
    if (do_chk) begin
      check_all(0);
      check_all(1);
    end
    @(posedge clk);
    m_update(0);
    m_update(1);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    m_clear(0);
    m_clear(1);
    @(posedge clk);
    #1;
    dbg_sweep("reset_dbg");
    check_all(0);
    check_all(1);
    reset = 1'b1;
    step(1);

    reg_write = 1; rd = 2; rd_data = 16'h1234;
    step(1);
    idle(); rs1 = 2; dbg_addr = 2;
    #1;
    chk("wr_rd_rs1", 0, a_rs1_data, 16'h1234);
    chk("wr_rd_cnt", 1, b_wb_count, 16'd1);
    step(1);

    reg_write = 1; rd = 3; rd_data = 16'hBEEF; rs2 = 3; dbg_addr = 3;
    #1;
    chk("bypass_a", 0, a_rs2_data, 16'hBEEF);
    chk("nobypass_b", 1, b_rs2_data, 16'h0000);
    step(1);
    idle(); rs2 = 3;
    step(1);

    issue_valid = 1; issue_rd = 5;
    step(1);
    idle(); rs1 = 5; rs1_en = 1;
    #1;
    chk("raw_stall", 0, a_stall, 1'b1);
    step(1);
    rs1_en = 0;
    step(1);
    rs1_en = 1; reg_write = 1; rd = 5; rd_data = 16'd7;
    #1;
    chk("wb_stall_a", 0, a_stall, 1'b0);
    chk("wb_stall_b", 1, b_stall, 1'b1);
    step(1);
    reg_write = 0;
    step(1);

    idle(); issue_valid = 1; issue_rd = 4;
    step(1);
    reg_write = 1; rd = 4; rd_data = 16'hA5A5;
    step(1);
    idle(); rs1 = 4; rs1_en = 1; dbg_addr = 4;
    #1;
    chk("collide_busy", 0, a_rs1_busy, 1'b1);
    chk("collide_data", 1, b_dbg_data, 16'hA5A5);
    step(1);

    idle(); reg_write = 1; rd = 0; rd_data = 16'hFFFF; issue_valid = 1; issue_rd = 0;
    step(1);
    idle(); rs1 = 0; rs1_en = 1;
    #1;
    chk("r0_zero", 1, b_rs1_data, 16'h0000);
    chk("r0_busy", 1, b_rs1_busy, 1'b0);
    step(1);

    for (int n = 0; n < 400; n++) begin
      rs1 = 3'($urandom); rs2 = 3'($urandom); rd = 3'($urandom);
      issue_rd = 3'($urandom); dbg_addr = 3'($urandom);
      rs1_en = 1'($urandom); rs2_en = 1'($urandom);
      reg_write = ($urandom_range(0, 2) == 0);
      issue_valid = ($urandom_range(0, 2) == 0);
      rd_data = 16'($urandom);
      if ($urandom_range(0, 9) == 0) rs2 = rs1;
      if ($urandom_range(0, 9) == 0) rd = rs1;
      step(1);
    end

    reg_write = 1; rd = 6; rd_data = 16'h5555; issue_valid = 1; issue_rd = 6;
    #2;
    reset = 1'b0;
    #1;
    m_clear(0);
    m_clear(1);
    dbg_sweep("async_rst_dbg");
    chk("async_rst_cnt", 0, a_wb_count, 16'd0);
    chk("async_rst_cnt", 1, b_wb_count, 16'd0);
    @(posedge clk);
    #1;
    rs1 = 6; rs1_en = 1; dbg_addr = 6;
    #1;
    chk("rst_drop_wr", 0, a_dbg_data, 16'd0);
    chk("rst_drop_wr", 1, b_dbg_data, 16'd0);
    chk("rst_drop_iss", 1, b_stall, 1'b0);
    chk("rst_drop_cnt", 0, a_wb_count, 16'd0);
    idle();
    reset = 1'b1;
    step(1);

    for (int n = 0; n < 65536; n++) begin
      reg_write = 1; rd = 3'($urandom_range(1, 7)); rd_data = 16'($urandom);
      step(0);
    end
    idle();
    #1;
    chk("wrap_cnt", 0, a_wb_count, 16'd0);
    chk("wrap_cnt", 1, b_wb_count, 16'd0);
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the CPU's 8x16 register file.
- Provides generic width/depth, two combinational read ports with write-to-read bypass, and an optional hardwired-zero r0.
- Adds a per-register busy scoreboard: set when an instruction issues, cleared on writeback. The pipelined CPU uses it to detect RAW hazards and raise a stall.
- Adds a debug read port and a writeback counter.

Parameters:
- DATA_W, 16: register width in bits.
- ADDR_W, 3: register address width; NREGS = 2**ADDR_W.
- ZERO_R0, 0: 1 = register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1: 1 = a same-cycle write is forwarded to the read ports and clears busy as seen by the reads.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- rs1  in  ADDR_W  read port 1 address
- rs2  in  ADDR_W  read port 2 address
- rs1_en  in  1  instruction uses rs1 (hazard qualifier)
- rs2_en  in  1  instruction uses rs2 (hazard qualifier)
- rs1_data  out  DATA_W  read port 1 data
- rs2_data  out  DATA_W  read port 2 data
- rd  in  ADDR_W  writeback address
- rd_data  in  DATA_W  writeback data
- reg_write  in  1  writeback enable
- issue_valid  in  1  an instruction writing issue_rd issues this cycle
- issue_rd  in  ADDR_W  destination of the issuing instruction
- rs1_busy  out  1  rs1 has a pending producer
- rs2_busy  out  1  rs2 has a pending producer
- stall  out  1  RAW hazard on an enabled source
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data (no bypass)
- wb_count  out  16  count of effective writebacks

Behaviour:
- Reset (reset low, async, no clock needed): all registers = 0, all busy bits = 0, wb_count = 0.
  - Outputs then read 0 and busy/stall = 0.
  - Reset asserted mid-operation discards any in-flight write or issue.
- Effective write: we = reg_write & ~(ZERO_R0 & rd==0).
  - On posedge with we, regs[rd] <= rd_data.
  - On posedge with we, wb_count <= wb_count+1, wrapping 0xFFFF -> 0x0000.
- Reads are combinational, zero latency: rsN_data = (BYPASS & we & rd==rsN) ? rd_data : regs[rsN].
  - With ZERO_R0, address 0 always reads 0.
  - rs1==rs2 is legal; both ports return identical data.
- dbg_data = regs[dbg_addr], combinational. It never bypasses, so it shows the committed state.
- Effective issue: ie = issue_valid & ~(ZERO_R0 & issue_rd==0).
- Busy update on posedge, per register i:
  - set if ie & issue_rd==i;
  - else clear if we & rd==i;
  - else hold.
  - Simultaneous set and clear of the same register: set wins, because the new producer supersedes.
  - Issue to an already-busy register (WAW) is allowed; busy simply stays 1.
  - Writeback to a non-busy register is legal; it writes data and busy stays 0.
- Busy as seen by the reads: rsN_busy = busy[rsN] & ~(BYPASS & we & rd==rsN).
  - With BYPASS=0, busy is visible until the cycle after the writeback edge.
- stall = (rs1_en & rs1_busy) | (rs2_en & rs2_busy). Combinational; no internal state machine beyond the busy vector and counter.
- Width rules:
  - rd_data is stored unmodified.
  - Addresses are full range 0..NREGS-1; there are no out-of-range values.

Test Plan:
- Reset then idle: hold reset low, release, read all 8 regs via dbg -> all 0x0000; stall=0; wb_count=0.
- Write and read: reg_write rd=2 rd_data=0x1234; next cycle rs1=2 -> 0x1234, dbg_addr=2 -> 0x1234, wb_count=1.
- Bypass (BYPASS=1): same cycle reg_write rd=3 data=0xBEEF with rs2=3 -> rs2_data=0xBEEF combinationally, dbg_data(3) still old value. With BYPASS=0, rs2_data shows the old value until after the edge.
- Scoreboard RAW:
  - issue_valid issue_rd=5; next cycle rs1=5 rs1_en=1 -> rs1_busy=1, stall=1.
  - Same with rs1_en=0 -> stall=0.
  - reg_write rd=5 data=7 -> stall drops the same cycle with BYPASS=1, or the next cycle with BYPASS=0; rs1_data=7.
- Set/clear collision: reg 4 busy; same cycle issue_rd=4 and reg_write rd=4 -> after the edge busy[4]=1 and regs[4]=new data.
- ZERO_R0=1: write 0xFFFF to r0 and issue to r0 -> r0 reads 0, rs1_busy=0, wb_count unchanged.
- Counter wrap: 65536 writebacks -> wb_count=0.
- Async reset mid-run: assert reset between edges -> all state 0 immediately.
